// File: rtl/mem_arbiter.sv
// Two-port (CPU, loader) arbiter in front of a single shared memory.
// One access at a time; round-robin on simultaneous requests.
module mem_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        ld_req,
    input  logic        ld_wr,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic [31:0] ld_rdata,
    output logic        ld_ack,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        cpu_stall
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [2:0] LAST_CNT  = 3'(READ_LAT);
    localparam logic       GRANT_CPU = 1'b0;
    localparam logic       GRANT_LD  = 1'b1;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  cnt;
    logic        last_grant;
    logic        grant_id;
    logic        pick_ld;
    logic        acc_wr;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    // On a tie the port that did not win last time gets the grant.
    assign pick_ld = (cpu_req && ld_req) ? (last_grant == GRANT_CPU) : ld_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            last_grant <= GRANT_LD;
            grant_id   <= GRANT_CPU;
            acc_wr     <= 1'b0;
            acc_addr   <= 32'd0;
            acc_wdata  <= 32'd0;
            cpu_rdata  <= 32'd0;
            ld_rdata   <= 32'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (cpu_req || ld_req) begin
                        grant_id  <= pick_ld;
                        acc_wr    <= pick_ld ? ld_wr    : cpu_wr;
                        acc_addr  <= pick_ld ? ld_addr  : cpu_addr;
                        acc_wdata <= pick_ld ? ld_wdata : cpu_wdata;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 3'd1;
                    if (!acc_wr && cnt == LAST_CNT) begin
                        if (grant_id == GRANT_LD) ld_rdata  <= mem_rdata;
                        else                      cpu_rdata <= mem_rdata;
                    end
                end
                DONE: last_grant <= grant_id;
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        mem_wr    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        cpu_ack   = 1'b0;
        ld_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || ld_req) state_nx = ACCESS;
            end
            ACCESS: begin
                mem_addr  = acc_addr;
                mem_wdata = acc_wdata;
                mem_wr    = acc_wr && (cnt == 3'd0);
                if (acc_wr || cnt == LAST_CNT) state_nx = DONE;
            end
            DONE: begin
                cpu_ack  = (grant_id == GRANT_CPU);
                ld_ack   = (grant_id == GRANT_LD);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cpu_stall = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with READ_LAT=1 (CPU + loader)
// and one with READ_LAT=3 (CPU only), both on a shared memory model.
module tb_mem_arbiter;
    logic        Clk = 1'b0;
    logic        reset;
    logic        cpu_req1, cpu_req3, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        ld_req, ld_wr;
    logic [31:0] ld_addr, ld_wdata;
    logic        ld_off;
    logic [31:0] ld_zero32;

    logic [31:0] cpu_rdata1, ld_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        cpu_ack1, ld_ack1, mem_wr1, cpu_stall1;
    logic [31:0] cpu_rdata3, ld_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        cpu_ack3, ld_ack3, mem_wr3, cpu_stall3;

    int total = 0;
    int bad   = 0;

    assign ld_off    = 1'b0;
    assign ld_zero32 = 32'd0;

    always #5 Clk = ~Clk;

    mem_arbiter #(.READ_LAT(1)) u_dut1 (
        .Clk(Clk), .reset(reset),
        .cpu_req(cpu_req1), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1),
        .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata1), .ld_ack(ld_ack1),
        .mem_addr(mem_addr1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .cpu_stall(cpu_stall1)
    );

    mem_arbiter #(.READ_LAT(3)) u_dut3 (
        .Clk(Clk), .reset(reset),
        .cpu_req(cpu_req3), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3),
        .ld_req(ld_off), .ld_wr(ld_off), .ld_addr(ld_zero32), .ld_wdata(ld_zero32),
        .ld_rdata(ld_rdata3), .ld_ack(ld_ack3),
        .mem_addr(mem_addr3), .mem_wr(mem_wr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .cpu_stall(cpu_stall3)
    );

    // Shared memory; read data is delayed by each instance's READ_LAT.
    logic [31:0] mem [0:63];
    logic [31:0] rd1, p3_0, p3_1, p3_2;
    always @(posedge Clk) begin
        if (mem_wr1) mem[mem_addr1[7:2]] <= mem_wdata1;
        if (mem_wr3) mem[mem_addr3[7:2]] <= mem_wdata3;
        rd1  <= mem[mem_addr1[7:2]];
        p3_0 <= mem[mem_addr3[7:2]];
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign mem_rdata1 = rd1;
    assign mem_rdata3 = p3_2;

    task automatic next_cyc();
        @(posedge Clk);
        #1;
    endtask

    // Counts cycles from the current one until the selected ack (0=cpu1,
    // 1=ld1, 2=cpu3); lat=-1 if it never comes. Returns at that cycle's negedge.
    task automatic wait_ack(input int which, output int lat, output bit other);
        logic hit;
        lat   = -1;
        other = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            case (which)
                0:       begin hit = cpu_ack1; other = other | ld_ack1;  end
                1:       begin hit = ld_ack1;  other = other | cpu_ack1; end
                default: hit = cpu_ack3;
            endcase
            if (hit) begin
                lat = k;
                break;
            end
            next_cyc();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req1 = 0; cpu_req3 = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_wr = 0; ld_addr = 0; ld_wdata = 0;
        next_cyc();
        next_cyc();
        @(negedge Clk);
        total++;
        if ({cpu_ack1, ld_ack1, cpu_ack3, ld_ack3} !== 4'b0) begin
            bad++; $display("FAIL reset_acks got=%b want=0000", {cpu_ack1, ld_ack1, cpu_ack3, ld_ack3});
        end
        total++;
        if ({mem_wr1, mem_wr3} !== 2'b0 || mem_addr1 !== 0 || mem_wdata1 !== 0 || mem_addr3 !== 0) begin
            bad++; $display("FAIL reset_mem got wr=%b addr=%h wdata=%h want 0", {mem_wr1, mem_wr3}, mem_addr1, mem_wdata1);
        end
        total++;
        if (cpu_rdata1 !== 0 || ld_rdata1 !== 0 || cpu_rdata3 !== 0) begin
            bad++; $display("FAIL reset_rdata got cpu=%h ld=%h want 0", cpu_rdata1, ld_rdata1);
        end
        next_cyc();
        reset = 1'b0;
    endtask

    task automatic test_cpu_write_read();
        int lat; bit other;
        next_cyc();
        cpu_req1 = 1; cpu_wr = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        wait_ack(0, lat, other);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL cpu_write_lat got=%0d want=2", lat); end
        next_cyc();
        cpu_req1 = 0;
        next_cyc();
        cpu_req1 = 1; cpu_wr = 0; cpu_addr = 32'h10;
        wait_ack(0, lat, other);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL cpu_read_lat got=%0d want=3", lat); end
        total++;
        if (cpu_rdata1 !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_read_data got=%h want=deadbeef", cpu_rdata1); end
        total++;
        if (other !== 1'b0 || ld_ack1 !== 1'b0) begin bad++; $display("FAIL cpu_read_ld_ack got=%b want=0", other); end
        next_cyc();
        cpu_req1 = 0;
    endtask

    task automatic test_ld_write();
        int lat; bit other;
        next_cyc();
        ld_req = 1; ld_wr = 1; ld_addr = 32'h20; ld_wdata = 32'h12345678;
        @(negedge Clk);
        total++;
        if (mem_wr1 !== 1'b0) begin bad++; $display("FAIL ld_wr_t0 got mem_wr=%b want=0", mem_wr1); end
        next_cyc();
        @(negedge Clk);
        total++;
        if (mem_wr1 !== 1'b1 || mem_addr1 !== 32'h20 || mem_wdata1 !== 32'h12345678) begin
            bad++; $display("FAIL ld_wr_t1 got wr=%b addr=%h data=%h want 1/20/12345678", mem_wr1, mem_addr1, mem_wdata1);
        end
        next_cyc();
        @(negedge Clk);
        total++;
        if (ld_ack1 !== 1'b1 || cpu_ack1 !== 1'b0 || mem_wr1 !== 1'b0 || mem_addr1 !== 0) begin
            bad++; $display("FAIL ld_wr_t2 got ld_ack=%b cpu_ack=%b wr=%b addr=%h want 1/0/0/0", ld_ack1, cpu_ack1, mem_wr1, mem_addr1);
        end
        next_cyc();
        ld_req = 0;
        next_cyc();
        cpu_req1 = 1; cpu_wr = 0; cpu_addr = 32'h20;
        wait_ack(0, lat, other);
        total++;
        if (lat !== 3 || cpu_rdata1 !== 32'h12345678) begin
            bad++; $display("FAIL cpu_readback got lat=%0d data=%h want 3/12345678", lat, cpu_rdata1);
        end
        total++;
        if (ld_rdata1 !== 32'h0) begin bad++; $display("FAIL ld_rdata_hold got=%h want=0", ld_rdata1); end
        next_cyc();
        cpu_req1 = 0;
        next_cyc();
        ld_req = 1; ld_wr = 0; ld_addr = 32'h10;
        wait_ack(1, lat, other);
        total++;
        if (lat !== 3 || ld_rdata1 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL ld_read got lat=%0d data=%h want 3/deadbeef", lat, ld_rdata1);
        end
        total++;
        if (cpu_rdata1 !== 32'h12345678) begin bad++; $display("FAIL cpu_rdata_hold got=%h want=12345678", cpu_rdata1); end
        next_cyc();
        ld_req = 0;
    endtask

    task automatic test_no_preempt();
        int lat; bit other;
        next_cyc();
        ld_req = 1; ld_wr = 1; ld_addr = 32'h24; ld_wdata = 32'h55AA;
        next_cyc();
        cpu_req1 = 1; cpu_wr = 0; cpu_addr = 32'h20;
        @(negedge Clk);
        total++;
        if (mem_wr1 !== 1'b1 || mem_addr1 !== 32'h24 || mem_wdata1 !== 32'h55AA || cpu_stall1 !== 1'b1) begin
            bad++; $display("FAIL preempt_access got wr=%b addr=%h data=%h stall=%b want 1/24/55aa/1", mem_wr1, mem_addr1, mem_wdata1, cpu_stall1);
        end
        next_cyc();
        @(negedge Clk);
        total++;
        if (ld_ack1 !== 1'b1 || cpu_ack1 !== 1'b0) begin
            bad++; $display("FAIL preempt_ld_ack got ld=%b cpu=%b want 1/0", ld_ack1, cpu_ack1);
        end
        next_cyc();
        ld_req = 0;
        wait_ack(0, lat, other);
        total++;
        if (lat !== 3 || cpu_rdata1 !== 32'h12345678) begin
            bad++; $display("FAIL preempt_cpu_after got lat=%0d data=%h want 3/12345678", lat, cpu_rdata1);
        end
        next_cyc();
        cpu_req1 = 0;
    endtask

    task automatic test_round_robin();
        logic exp_cpu, exp_ld;
        next_cyc();
        reset = 1;
        cpu_req1 = 1; cpu_wr = 1; cpu_addr = 32'h40; cpu_wdata = 32'hA;
        ld_req = 1; ld_wr = 1; ld_addr = 32'h44; ld_wdata = 32'hB;
        next_cyc();
        reset = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            exp_cpu = (c == 2) || (c == 8);
            exp_ld  = (c == 5) || (c == 11);
            total++;
            if (cpu_ack1 !== exp_cpu || ld_ack1 !== exp_ld) begin
                bad++; $display("FAIL rr_cycle%0d got cpu=%b ld=%b want cpu=%b ld=%b", c, cpu_ack1, ld_ack1, exp_cpu, exp_ld);
            end
            next_cyc();
        end
        cpu_req1 = 0;
        ld_req = 0;
    endtask

    task automatic test_lat3();
        logic        exp_stall, exp_ack;
        logic [31:0] exp_addr;
        next_cyc();
        cpu_req3 = 1; cpu_wr = 0; cpu_addr = 32'h10;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            exp_stall = (c < 5);
            exp_ack   = (c == 5);
            exp_addr  = (c >= 1 && c <= 4) ? 32'h10 : 32'h0;
            total++;
            if (cpu_stall3 !== exp_stall || cpu_ack3 !== exp_ack || mem_addr3 !== exp_addr) begin
                bad++; $display("FAIL lat3_cycle%0d got stall=%b ack=%b addr=%h want %b/%b/%h", c, cpu_stall3, cpu_ack3, mem_addr3, exp_stall, exp_ack, exp_addr);
            end
            next_cyc();
        end
        total++;
        if (cpu_rdata3 !== 32'hDEADBEEF) begin bad++; $display("FAIL lat3_data got=%h want=deadbeef", cpu_rdata3); end
        cpu_req3 = 0;
    endtask

    task automatic test_reset_abort();
        int lat; bit other;
        next_cyc();
        cpu_req3 = 1; cpu_wr = 0; cpu_addr = 32'h20;
        next_cyc();
        next_cyc();
        reset = 1;
        @(negedge Clk);
        total++;
        if (cpu_ack3 !== 1'b0) begin bad++; $display("FAIL abort_ack_during got=%b want=0", cpu_ack3); end
        next_cyc();
        reset = 0;
        @(negedge Clk);
        total++;
        if (cpu_ack3 !== 1'b0 || mem_wr3 !== 1'b0 || mem_addr3 !== 0 || cpu_rdata3 !== 0) begin
            bad++; $display("FAIL abort_reset_vals got ack=%b wr=%b addr=%h rdata=%h want 0", cpu_ack3, mem_wr3, mem_addr3, cpu_rdata3);
        end
        next_cyc();
        wait_ack(2, lat, other);
        total++;
        if (lat !== 4 || cpu_rdata3 !== 32'h12345678) begin
            bad++; $display("FAIL abort_retry got lat=%0d data=%h want 4/12345678", lat, cpu_rdata3);
        end
        next_cyc();
        cpu_req3 = 0;
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_ld_write();
        test_no_preempt();
        test_round_robin();
        test_lat3();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: READ_LAT, default 1, legal range 1..7; cycles from mem_addr driven to mem_rdata valid.
REQ-002 Port: Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  reset is synchronous and active-high.
REQ-004 Port: cpu_req  in  1  CPU access request; held high with stable cpu_wr/addr/wdata until cpu_ack.
REQ-005 Port: cpu_wr  in  1  1 = write, 0 = read.
REQ-006 Port: cpu_addr  in  32  CPU byte address.
REQ-007 Port: cpu_wdata  in  32  CPU write data.
REQ-008 Port: cpu_rdata  out  32  CPU read data; valid while cpu_ack=1.
REQ-009 Port: cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-010 Port: ld_req, ld_wr, ld_addr[32], ld_wdata[32]  in  loader/debug port; same rules as CPU port.
REQ-011 Port: ld_rdata  out  32, ld_ack  out  1  loader read data and completion pulse.
REQ-012 Port: mem_addr  out  32  address to the shared memory.
REQ-013 Port: mem_wr  out  1  memory write strobe.
REQ-014 Port: mem_wdata  out  32  memory write data.
REQ-015 Port: mem_rdata  in  32  memory read data.
REQ-016 Port: cpu_stall  out  1  = cpu_req and not cpu_ack; the CPU control unit holds its state while high.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE; one access outstanding at a time.
REQ-018 IDLE: requests sampled; if any asserted, grant one, latch its wr/addr/wdata and requester ID, go to ACCESS; otherwise stay.
REQ-019 Arbitration: lone requester wins; on a tie, the requester not granted last wins (round-robin via last_grant register).
REQ-020 ACCESS: mem_addr = latched addr; mem_wdata = latched wdata; 3-bit cycle counter cnt starts at 0 on entry and increments each cycle.
REQ-021 Write: mem_wr = 1 only in the first ACCESS cycle (cnt = 0), then go to DONE.
REQ-022 Read: mem_wr = 0; stay in ACCESS until cnt = READ_LAT, capture mem_rdata into the granted port's rdata register on that edge, go to DONE.
REQ-023 DONE: granted port's ack = 1 for exactly one cycle; other ack = 0; last_grant updated; next state IDLE.
REQ-024 Latency, req seen in IDLE at cycle t: write ack at t+2; read ack at t+2+READ_LAT; IDLE again the following cycle.
REQ-025 Requester drops or changes req on the edge ending its ack cycle; a req still high in IDLE is a new request.
REQ-026 In IDLE and DONE: mem_wr = 0, mem_addr = 0, mem_wdata = 0.
REQ-027 A request arriving during ACCESS/DONE waits; it never preempts or alters the access in progress.
REQ-028 cpu_rdata/ld_rdata hold their last captured value until the next read for that port; writes leave them unchanged.
REQ-029 cpu_ack and ld_ack are never high in the same cycle.

Reset
REQ-030 reset high at a rising edge: state = IDLE, cnt = 0, last_grant = loader (first tie goes to CPU), cpu_rdata = ld_rdata = 0, both acks = 0, mem_wr = 0, mem_addr = mem_wdata = 0.
REQ-031 reset during ACCESS/DONE aborts the access: no ack is issued, mem_wr is 0 from the next cycle, and the pending request is re-arbitrated after reset is released.

Verification
REQ-032 CPU read, READ_LAT=1, addr 0x10, memory word 0xDEADBEEF -> cpu_ack at t+3, cpu_rdata = 0xDEADBEEF, ld_ack = 0.
REQ-033 Loader write, addr 0x20, data 0x12345678 -> mem_wr high exactly at t+1 with that addr/data; ld_ack at t+2; readback by CPU returns 0x12345678.
REQ-034 Both req high from reset, held continuously, all writes -> grants alternate CPU, LD, CPU, LD; acks at t+2, t+5, t+8, t+11.
REQ-035 READ_LAT=3, CPU read -> ack at t+5; mem_addr stable for ACCESS cycles t+1..t+4; cpu_stall high t..t+4, low at t+5.
REQ-036 reset pulsed in the READ_LAT=3 read's second ACCESS cycle -> no cpu_ack, outputs at reset values; with cpu_req still high, read completes with ack 5 cycles after reset drops.
REQ-037 LD write granted while cpu_req rises mid-access -> LD access completes unchanged, then CPU granted in the next IDLE.
